pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined WIDTH-bit adder/subtractor with valid/ready handshakes on both sides. It splits the operand into STAGES equal chunks and adds one chunk per pipeline stage, rippling the carry between stages. It accepts one operation per cycle and supports downstream backpressure. It is the registered successor to the combinational `thirtytwo_bit_adder` and is intended for datapaths where a full-width carry chain will not close timing.

## Interface
Parameters:
- WIDTH, 32: operand and result width; must be a multiple of STAGES.
- STAGES, 4: number of pipeline stages (1..WIDTH); each stage adds a CHUNK = WIDTH/STAGES bit slice.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry in (add) or borrow in (sub).
- op  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- Sum  output  WIDTH  result.
- Cout  output  1  carry out; in subtract mode, 1 = no borrow.
- Ovf  output  1  two's-complement signed overflow.

## Operation
- Arithmetic:
  - op=0: {Cout,Sum} = A + B + Cin.
  - op=1: {Cout,Sum} = A + ~B + ~Cin, i.e. A − B − Cin.
  - Ovf = (A'[W-1] == B'[W-1]) && (Sum[W-1] != A'[W-1]), where B' is the effective (possibly inverted) B.
- Transfer rules:
  - Accept on in_valid && in_ready.
  - Deliver on out_valid && out_ready.
- Stage 0 registers the full operands, op and effective B/carry. It adds chunk 0 and registers chunk sum 0 plus the carry.
- Stage k (k ≥ 1) adds chunk k using the carry from stage k−1. It forwards completed low chunks and the remaining upper operand chunks.
- The last stage holds the complete Sum, Cout and Ovf.
- Each stage has a valid bit. Stage k loads when it is empty or when stage k+1 loads or drains this cycle; otherwise it holds.
- in_ready = stage-0 load condition, derived combinationally from out_ready through the valid chain; no bubble on a continuous stream.
- While out_valid && !out_ready, Sum, Cout and Ovf are held stable. When out_valid=0, these outputs are don't-care.
- No operation is dropped, duplicated or reordered.

## Timing
- Reset (asynchronous, active-high):
  - All stage valid bits = 0.
  - out_valid=0, Sum=0, Cout=0, Ovf=0.
  - in_ready=1 from the first cycle after rst deasserts.
- Reset mid-operation discards all in-flight operations immediately; nothing is emitted after rst falls until new inputs arrive.
- Latency: an operation accepted at edge n shows out_valid=1 after edge n+STAGES−1, i.e. STAGES cycles. With STAGES=1, the result is registered after a single edge.
- Throughput: one operation per cycle while out_ready=1.
- Full pipeline plus out_ready=0: in_ready=0 in the same cycle.
- When out_ready rises again, in_ready=1 in the same cycle.
- A simultaneous accept and deliver in the same cycle is legal at every occupancy.
- Inputs are sampled only on an accepting edge. A, B, Cin and op may change freely otherwise.
- Carry wrap-around: the carry out of the top chunk becomes Cout; no carry is ever fed back into chunk 0.

## Test plan
- Reset then add, WIDTH=32 STAGES=4: A=0xFFFFFFFF, B=0xFFFFFFFF, Cin=0, op=0 → after 4 cycles Sum=0xFFFFFFFE, Cout=1, Ovf=0. Then A=B=0, Cin=0 → Sum=0, Cout=0.
- Signed overflow: A=0x7FFFFFFF, B=1, op=0 → Sum=0x80000000, Cout=0, Ovf=1. Then op=1, A=5, B=7, Cin=0 → Sum=0xFFFFFFFE, Cout=0, Ovf=0.
- Streaming: 16 back-to-back random ops with out_ready=1 → results emitted in order on 16 consecutive cycles, each matching a reference model, with in_ready constantly 1.
- Backpressure: fill the pipeline, then hold out_ready=0 for 6 cycles → in_ready=0, Sum held stable, no loss. Release → remaining results drain in order.
- Reset mid-stream: assert rst with 3 ops in flight → out_valid=0 and Sum=0 immediately. After release, no stale results appear and the next op returns a correct result.
- Parameter sweep: STAGES=1, WIDTH=8 and STAGES=8, WIDTH=64. Check that latency equals STAGES and that results match exhaustive (8-bit) or random (64-bit) models.

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract: one CHUNK-bit slice per stage, carry rippled stage to stage; latency STAGES cycles.
// Backpressure: a stage loads when it is empty or everything behind it can move, so in_ready falls only when the whole pipe is full and stalled.
module pipelined_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Ovf
);
   localparam int CHUNK = WIDTH / STAGES;

   logic [STAGES-1:0] valid_q, valid_d, load;
   logic [STAGES-1:0] carry_q, carry_d, carry_in;
   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  a_d   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic [WIDTH-1:0]  b_d   [STAGES];
   logic [WIDTH-1:0]  sum_q [STAGES];
   logic [WIDTH-1:0]  sum_d [STAGES];
   logic [WIDTH-1:0]  a_in  [STAGES];
   logic [WIDTH-1:0]  b_in  [STAGES];
   logic [WIDTH-1:0]  sum_in[STAGES];
   logic [CHUNK:0]    part  [STAGES];
   logic              full_tail;

   // Stage k may load unless it and every stage after it are valid while the output stalls.
   always_comb begin
      load      = '0;
      full_tail = 1'b1;
      for (int k = STAGES - 1; k >= 0; k--) begin
         full_tail = full_tail & valid_q[k];
         load[k]   = out_ready | ~full_tail;
      end
   end

   always_comb begin
      a_in[0]     = A;
      b_in[0]     = op ? ~B : B;
      carry_in    = '0;
      carry_in[0] = Cin ^ op;
      sum_in[0]   = '0;
      for (int k = 1; k < STAGES; k++) begin
         a_in[k]     = a_q[k-1];
         b_in[k]     = b_q[k-1];
         carry_in[k] = carry_q[k-1];
         sum_in[k]   = sum_q[k-1];
      end

      valid_d    = valid_q;
      carry_d    = carry_q;
      valid_d[0] = load[0] ? in_valid : valid_q[0];
      for (int k = 1; k < STAGES; k++) begin
         valid_d[k] = load[k] ? valid_q[k-1] : valid_q[k];
      end

      for (int k = 0; k < STAGES; k++) begin
         part[k]  = {1'b0, a_in[k][k*CHUNK +: CHUNK]} + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry_in[k]};
         a_d[k]   = a_q[k];
         b_d[k]   = b_q[k];
         sum_d[k] = sum_q[k];
         if (load[k]) begin
            a_d[k]                      = a_in[k];
            b_d[k]                      = b_in[k];
            sum_d[k]                    = sum_in[k];
            sum_d[k][k*CHUNK +: CHUNK]  = part[k][CHUNK-1:0];
            carry_d[k]                  = part[k][CHUNK];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         carry_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         carry_q <= carry_d;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= a_d[k];
            b_q[k]   <= b_d[k];
            sum_q[k] <= sum_d[k];
         end
      end
   end

   assign in_ready  = load[0];
   assign out_valid = valid_q[STAGES-1];
   assign Sum       = sum_q[STAGES-1];
   assign Cout      = carry_q[STAGES-1];
   // b_q carries the effective (possibly inverted) B, so overflow uses it directly.
   assign Ovf       = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
                      (sum_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and sweep checks for pipelined_adder at 32/4, 8/1 and 64/8.
module tb_pipelined_adder;
   typedef struct {
      logic [31:0] a, b;
      logic        cin, op;
      logic [31:0] s;
      logic        c, v;
   } vec_t;

   typedef struct {
      logic [63:0] s;
      logic        c, v;
      int          due;
   } exp_t;

   logic clk, rst;
   int   cyc;
   int   n_pass, n_tot;

   logic        m_in_valid, m_in_ready, m_cin, m_op, m_out_valid, m_out_ready, m_cout, m_ovf;
   logic [31:0] m_a, m_b, m_sum;
   logic        s8_in_valid, s8_in_ready, s8_cin, s8_op, s8_out_valid, s8_cout, s8_ovf;
   logic [7:0]  s8_a, s8_b, s8_sum;
   logic        s64_in_valid, s64_in_ready, s64_cin, s64_op, s64_out_valid, s64_cout, s64_ovf;
   logic [63:0] s64_a, s64_b, s64_sum;

   vec_t vecs[12];
   exp_t qm[$];
   exp_t q8[$];
   exp_t q64[$];

   pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
      .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
      .A(m_a), .B(m_b), .Cin(m_cin), .op(m_op), .out_valid(m_out_valid),
      .out_ready(m_out_ready), .Sum(m_sum), .Cout(m_cout), .Ovf(m_ovf));

   pipelined_adder #(.WIDTH(8), .STAGES(1)) dut8 (
      .clk(clk), .rst(rst), .in_valid(s8_in_valid), .in_ready(s8_in_ready),
      .A(s8_a), .B(s8_b), .Cin(s8_cin), .op(s8_op), .out_valid(s8_out_valid),
      .out_ready(1'b1), .Sum(s8_sum), .Cout(s8_cout), .Ovf(s8_ovf));

   pipelined_adder #(.WIDTH(64), .STAGES(8)) dut64 (
      .clk(clk), .rst(rst), .in_valid(s64_in_valid), .in_ready(s64_in_ready),
      .A(s64_a), .B(s64_b), .Cin(s64_cin), .op(s64_op), .out_valid(s64_out_valid),
      .out_ready(1'b1), .Sum(s64_sum), .Cout(s64_cout), .Ovf(s64_ovf));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %h want %h", nm, act, exp);
      else n_pass++;
   endtask

   // Full-width reference: {Cout,Sum} = A + B' + Cin' with overflow from sign bits.
   function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic cin, input logic op, input int due);
      exp_t        e;
      logic [64:0] t;
      logic [63:0] m, am, bb;
      m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      am = a & m;
      bb = (op ? ~b : b) & m;
      t  = {1'b0, am} + {1'b0, bb} + {64'd0, cin ^ op};
      e.s   = t[63:0] & m;
      e.c   = t[w];
      e.v   = (am[w-1] == bb[w-1]) && (t[w-1] != am[w-1]);
      e.due = due;
      return e;
   endfunction

   task automatic run_one(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic op,
                          input logic [31:0] s, input logic c, input logic v);
      int lat;
      @(negedge clk);
      m_out_ready = 1'b1;
      m_in_valid = 1'b1; m_a = a; m_b = b; m_cin = cin; m_op = op;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      m_in_valid = 1'b0; m_a = '1; m_b = '1; m_cin = ~cin; m_op = ~op;
      while (!m_out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk({nm, "_latency"}, 64'(lat), 64'd4);
      chk({nm, "_sum"}, {32'd0, m_sum}, {32'd0, s});
      chk({nm, "_cout"}, {63'd0, m_cout}, {63'd0, c});
      chk({nm, "_ovf"}, {63'd0, m_ovf}, {63'd0, v});
   endtask

   task automatic mon_main(input bit check_due);
      exp_t e;
      if (m_out_valid && m_out_ready) begin
         if (qm.size() == 0) chk("main_spurious_out", 64'd1, 64'd0);
         else begin
            e = qm.pop_front();
            chk("main_sum", {32'd0, m_sum}, e.s);
            chk("main_cout", {63'd0, m_cout}, {63'd0, e.c});
            chk("main_ovf", {63'd0, m_ovf}, {63'd0, e.v});
            if (check_due) chk("main_lat", 64'(cyc), 64'(e.due));
         end
      end
   endtask

   task automatic push_main();
      m_in_valid = 1'b1;
      m_a = $urandom; m_b = $urandom; m_cin = 1'($urandom); m_op = 1'($urandom);
      if (m_in_ready) qm.push_back(model(32, {32'd0, m_a}, {32'd0, m_b}, m_cin, m_op, cyc + 4));
   endtask

   initial begin
      exp_t e;
      int   n_sweep;
      n_pass = 0; n_tot = 0; cyc = 0;
      vecs[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0};
      vecs[1]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0};
      vecs[2]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
      vecs[3]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
      vecs[4]  = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
      vecs[5]  = '{32'h00FFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h01000000, 1'b0, 1'b0};
      vecs[6]  = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0};
      vecs[7]  = '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0};
      vecs[8]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
      vecs[9]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
      vecs[10] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
      vecs[11] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};

      rst = 1'b1;
      m_in_valid = 0; m_a = 0; m_b = 0; m_cin = 0; m_op = 0; m_out_ready = 1;
      s8_in_valid = 0; s8_a = 0; s8_b = 0; s8_cin = 0; s8_op = 0;
      s64_in_valid = 0; s64_a = 0; s64_b = 0; s64_cin = 0; s64_op = 0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", {63'd0, m_out_valid}, 64'd0);
      chk("rst_sum", {32'd0, m_sum}, 64'd0);
      chk("rst_cout", {63'd0, m_cout}, 64'd0);
      chk("rst_ovf", {63'd0, m_ovf}, 64'd0);
      chk("rst_out_valid_8", {63'd0, s8_out_valid}, 64'd0);
      chk("rst_out_valid_64", {63'd0, s64_out_valid}, 64'd0);
      rst = 1'b0;
      #1 chk("rst_in_ready", {63'd0, m_in_ready}, 64'd1);

      for (int i = 0; i < 12; i++)
         run_one($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op,
                 vecs[i].s, vecs[i].c, vecs[i].v);

      // Streaming: 16 back-to-back ops, results due on consecutive cycles.
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         mon_main(1'b1);
         if (i < 16) begin
            chk("stream_in_ready", {63'd0, m_in_ready}, 64'd1);
            push_main();
         end else m_in_valid = 1'b0;
      end
      chk("stream_drained", 64'(qm.size()), 64'd0);

      // Backpressure: fill, stall six cycles, release with a simultaneous accept.
      @(negedge clk);
      m_out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         chk("fill_in_ready", {63'd0, m_in_ready}, 64'd1);
         push_main();
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         push_main();
         chk("stall_in_ready", {63'd0, m_in_ready}, 64'd0);
         chk("stall_out_valid", {63'd0, m_out_valid}, 64'd1);
         chk("stall_sum_held", {32'd0, m_sum}, qm[0].s);
         chk("stall_queue", 64'(qm.size()), 64'd4);
      end
      @(negedge clk);
      m_out_ready = 1'b1;
      #1 chk("release_in_ready", {63'd0, m_in_ready}, 64'd1);
      mon_main(1'b0);
      push_main();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         m_in_valid = 1'b0;
         mon_main(1'b0);
      end
      chk("bp_drained", 64'(qm.size()), 64'd0);

      // Reset with three ops in flight.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mon_main(1'b1);
         push_main();
      end
      @(negedge clk);
      m_in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", {63'd0, m_out_valid}, 64'd0);
      chk("midrst_sum", {32'd0, m_sum}, 64'd0);
      chk("midrst_cout", {63'd0, m_cout}, 64'd0);
      qm.delete();
      @(negedge clk);
      rst = 1'b0;
      #1 chk("midrst_in_ready", {63'd0, m_in_ready}, 64'd1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("midrst_no_stale", {63'd0, m_out_valid}, 64'd0);
      end
      e = model(32, 64'h12345678, 64'h9ABCDEF0, 1'b1, 1'b1, 0);
      run_one("post_rst", 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b1, e.s[31:0], e.c, e.v);

      // Parameter sweep: every 8-bit A against 64 B patterns, random 64-bit ops.
      n_sweep = 16384;
      for (int i = 0; i < n_sweep + 12; i++) begin
         @(negedge clk);
         if (s8_out_valid) begin
            if (q8.size() == 0) chk("s8_spurious_out", 64'd1, 64'd0);
            else begin
               e = q8.pop_front();
               chk("s8_sum", {56'd0, s8_sum}, e.s);
               chk("s8_cout", {63'd0, s8_cout}, {63'd0, e.c});
               chk("s8_ovf", {63'd0, s8_ovf}, {63'd0, e.v});
               chk("s8_lat", 64'(cyc), 64'(e.due));
            end
         end
         if (s64_out_valid) begin
            if (q64.size() == 0) chk("s64_spurious_out", 64'd1, 64'd0);
            else begin
               e = q64.pop_front();
               chk("s64_sum", s64_sum, e.s);
               chk("s64_cout", {63'd0, s64_cout}, {63'd0, e.c});
               chk("s64_ovf", {63'd0, s64_ovf}, {63'd0, e.v});
               chk("s64_lat", 64'(cyc), 64'(e.due));
            end
         end
         if (i < n_sweep) begin
            s8_in_valid = 1'b1;
            s8_a = i[7:0]; s8_b = {i[13:8], i[3:2]};
            s8_op = i[4] ^ i[8]; s8_cin = i[5] ^ i[9];
            q8.push_back(model(8, {56'd0, s8_a}, {56'd0, s8_b}, s8_cin, s8_op, cyc + 1));
            s64_in_valid = 1'b1;
            s64_a = {$urandom, $urandom}; s64_b = {$urandom, $urandom};
            s64_cin = 1'($urandom); s64_op = 1'($urandom);
            q64.push_back(model(64, s64_a, s64_b, s64_cin, s64_op, cyc + 8));
         end else begin
            s8_in_valid = 1'b0;
            s64_in_valid = 1'b0;
         end
      end
      chk("s8_drained", 64'(q8.size()), 64'd0);
      chk("s64_drained", 64'(q64.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
